vedic_mul8_pipe: RTL and testbench

- Pipelined 8x8 unsigned Urdhva-Tiryagbhyam multiplier. It consumes the `ha` half-adder cells through 2x2 and 4x4 vedic sub-blocks and is the next stage up the multiplier hierarchy.
- Accepts operand pairs over a valid/ready handshake.
- Returns the 16-bit product 3 cycles later with a passthrough tag.
- Keeps a running count of completed products for the system-level throughput test.

---
 rtl/vedic_mul8_pipe_if.sv | 25 ++
 rtl/vedic_mul8_pipe.sv | 190 +++++++++++++++++++
 tb/tb_vedic_mul8_pipe.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vedic_mul8_pipe_if.sv
// Operand/product handshake bundle for the pipelined 8x8 vedic multiplier.
// master drives operands and out_ready; slave is the multiplier side.
interface vedic_mul8_pipe_if #(
    parameter int unsigned TAG_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_p;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_p, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_p, out_tag
    );
endinterface

// File: rtl/vedic_mul8_pipe.sv
// 3-stage pipelined 8x8 unsigned Urdhva-Tiryagbhyam multiplier with tag passthrough,
// per-stage valid/ready flow control (bubble collapsing) and a hand-off counter.
module vedic_mul8_pipe #(
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    vedic_mul8_pipe_if.slave bus,
    output logic [CNT_W-1:0] prod_cnt
);

    // Bit cells return {carry, sum}.
    function automatic logic [1:0] ha(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    function automatic logic [1:0] fa(input logic x, input logic y, input logic c);
        logic [1:0] s0;
        logic [1:0] s1;
        s0 = ha(x, y);
        s1 = ha(s0[0], c);
        return {s0[1] | s1[1], s1[0]};
    endfunction

    function automatic logic [3:0] vedic2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] h0;
        logic [1:0] h1;
        h0 = ha(a[1] & b[0], a[0] & b[1]);
        h1 = ha(a[1] & b[1], h0[1]);
        return {h1[1], h1[0], h0[0], a[0] & b[0]};
    endfunction

    function automatic logic [7:0] vedic4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p0;
        logic [3:0] p1;
        logic [3:0] p2;
        logic [3:0] p3;
        logic [4:0] m;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] s;
        logic [1:0] r;
        logic       c;
        p0 = vedic2(a[1:0], b[1:0]);
        p1 = vedic2(a[3:2], b[1:0]);
        p2 = vedic2(a[1:0], b[3:2]);
        p3 = vedic2(a[3:2], b[3:2]);
        c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r    = fa(p1[i], p2[i], c);
            m[i] = r[0];
            c    = r[1];
        end
        m[4] = c;
        x = {p3, p0};
        y = {1'b0, m, 2'b00};
        c = 1'b0;
        // The 4x4 product fits in 8 bits, so the final carry is always zero.
        for (int i = 0; i < 8; i++) begin
            r    = fa(x[i], y[i], c);
            s[i] = r[0];
            c    = r[1];
        end
        return s;
    endfunction

    function automatic logic [8:0] add8(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] s;
        logic [1:0] r;
        logic       c;
        c = 1'b0;
        for (int i = 0; i < 8; i++) begin
            r    = fa(x[i], y[i], c);
            s[i] = r[0];
            c    = r[1];
        end
        return {c, s};
    endfunction

    function automatic logic [15:0] add16(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] s;
        logic [1:0]  r;
        logic        c;
        c = 1'b0;
        for (int i = 0; i < 16; i++) begin
            r    = fa(x[i], y[i], c);
            s[i] = r[0];
            c    = r[1];
        end
        return s;
    endfunction

    logic             ready1, ready2, ready3;
    logic             v1_q, v2_q, v3_q;
    logic [7:0]       q0_q, q1_q, q2_q, q3_q;
    logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
    logic [8:0]       m_q;
    logic [7:0]       lo_q, hi_q;
    logic [15:0]      p_q;
    logic [CNT_W-1:0] cnt_q;

    logic [7:0]       q0_d, q1_d, q2_d, q3_d;
    logic [8:0]       m_d;
    logic [15:0]      p_d;

    // Ready ripples back combinationally so any bubble is filled immediately.
    always_comb begin
        ready3 = !v3_q || bus.out_ready;
        ready2 = !v2_q || ready3;
        ready1 = !v1_q || ready2;
    end

    always_comb begin
        q0_d = vedic4(bus.in_a[3:0], bus.in_b[3:0]);
        q1_d = vedic4(bus.in_a[7:4], bus.in_b[3:0]);
        q2_d = vedic4(bus.in_a[3:0], bus.in_b[7:4]);
        q3_d = vedic4(bus.in_a[7:4], bus.in_b[7:4]);
        m_d  = add8(q1_q, q2_q);
        // Max product is 0xFE01, so dropping the carry out of bit 15 is safe.
        p_d  = add16({hi_q, lo_q}, {3'b000, m_q, 4'b0000});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            q0_q   <= '0;
            q1_q   <= '0;
            q2_q   <= '0;
            q3_q   <= '0;
            tag1_q <= '0;
        end else if (ready1) begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) begin
                q0_q   <= q0_d;
                q1_q   <= q1_d;
                q2_q   <= q2_d;
                q3_q   <= q3_d;
                tag1_q <= bus.in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q   <= 1'b0;
            m_q    <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
            tag2_q <= '0;
        end else if (ready2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                m_q    <= m_d;
                lo_q   <= q0_q;
                hi_q   <= q3_q;
                tag2_q <= tag1_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q   <= 1'b0;
            p_q    <= '0;
            tag3_q <= '0;
        end else if (ready3) begin
            v3_q <= v2_q;
            if (v2_q) begin
                p_q    <= p_d;
                tag3_q <= tag2_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (v3_q && bus.out_ready) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.in_ready  = ready1;
    assign bus.out_valid = v3_q;
    assign bus.out_p     = p_q;
    assign bus.out_tag   = tag3_q;
    assign prod_cnt      = cnt_q;

endmodule

// File: tb/tb_vedic_mul8_pipe.sv
// Directed and randomised checks of vedic_mul8_pipe against a queue of expected
// {tag, a*b} entries; CNT_W is shrunk to 4 so the counter wrap is reachable.
module tb_vedic_mul8_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  prod_cnt;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [19:0] sb[$];
    logic [3:0]  exp_cnt = '0;
    int          accepted;

    vedic_mul8_pipe_if #(.TAG_W(4)) bus ();

    vedic_mul8_pipe #(
        .TAG_W(4),
        .CNT_W(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .prod_cnt (prod_cnt)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] t);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = t;
    endtask

    // Scoreboard: sampled mid-cycle, the handshakes seen here complete at the next edge.
    always @(negedge clk) begin
        logic [19:0] e;
        if (rst_n) begin
            check("prod_cnt", 32'(prod_cnt), 32'(exp_cnt));
            if (bus.out_valid && bus.out_ready) begin
                e = (sb.size() != 0) ? sb.pop_front() : 'x;
                check("sb_product", 32'(bus.out_p), 32'(e[15:0]));
                check("sb_tag", 32'(bus.out_tag), 32'(e[19:16]));
                exp_cnt++;
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back({bus.in_tag, 16'(bus.in_a) * 16'(bus.in_b)});
        end
    end

    initial begin
        logic [7:0]  ca[4];
        logic [7:0]  cb[4];
        logic [15:0] ce[4];
        logic [7:0]  pa[4];
        logic [7:0]  pb[4];
        ca = '{8'd255, 8'd0, 8'd1, 8'd240};
        cb = '{8'd255, 8'd200, 8'd1, 8'd15};
        ce = '{16'hFE01, 16'h0000, 16'h0001, 16'h0E10};
        pa = '{8'd3, 8'd200, 8'd17, 8'd128};
        pb = '{8'd7, 8'd100, 8'd19, 8'd2};

        drive(1'b0, 8'd0, 8'd0, 4'd0);
        bus.out_ready = 1'b0;
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_p", 32'(bus.out_p), 0);
        check("rst_out_tag", 32'(bus.out_tag), 0);
        check("rst_prod_cnt", 32'(prod_cnt), 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 1);
        tick();

        // Single transfer and its latency
        bus.out_ready = 1'b1;
        drive(1'b1, 8'd13, 8'd11, 4'd5);
        #1;
        check("single_in_ready", 32'(bus.in_ready), 1);
        tick();
        drive(1'b0, 8'd0, 8'd0, 4'd0);
        check("lat_c1", 32'(bus.out_valid), 0);
        tick();
        check("lat_c2", 32'(bus.out_valid), 0);
        tick();
        check("lat_c3_valid", 32'(bus.out_valid), 1);
        check("lat_c3_p", 32'(bus.out_p), 32'h008F);
        check("lat_c3_tag", 32'(bus.out_tag), 5);
        tick();
        check("single_cnt", 32'(prod_cnt), 1);
        check("single_drained", 32'(bus.out_valid), 0);

        // Corner operands back to back
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                drive(1'b1, ca[c], cb[c], 4'(c + 8));
                #1;
                check("corner_in_ready", 32'(bus.in_ready), 1);
            end else begin
                drive(1'b0, 8'd0, 8'd0, 4'd0);
            end
            tick();
            if (c >= 2) begin
                check("corner_valid", 32'(bus.out_valid), 1);
                check("corner_p", 32'(bus.out_p), 32'(ce[c-2]));
            end
        end
        tick();

        // Backpressure: three fill the pipe, the fourth waits
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, pa[c], pb[c], 4'(c));
            #1;
            check("bp_accept", 32'(bus.in_ready), 1);
            tick();
        end
        drive(1'b1, pa[3], pb[3], 4'd3);
        for (int c = 0; c < 2; c++) begin
            #1;
            check("bp_full_ready", 32'(bus.in_ready), 0);
            check("bp_hold_valid", 32'(bus.out_valid), 1);
            check("bp_hold_p", 32'(bus.out_p), 32'd21);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.in_ready), 1);
        check("bp_release_p", 32'(bus.out_p), 32'd21);
        tick();
        drive(1'b0, 8'd0, 8'd0, 4'd0);
        for (int k = 1; k < 4; k++) begin
            check("bp_drain_valid", 32'(bus.out_valid), 1);
            check("bp_drain_p", 32'(bus.out_p), 32'(16'(pa[k]) * 16'(pb[k])));
            tick();
        end
        check("bp_empty", 32'(bus.out_valid), 0);

        // Bubble collapse with the output stalled
        bus.out_ready = 1'b0;
        drive(1'b1, 8'd9, 8'd9, 4'd1);
        #1;
        check("bub_ready0", 32'(bus.in_ready), 1);
        tick();
        drive(1'b0, 8'd0, 8'd0, 4'd0);
        check("bub_ready1", 32'(bus.in_ready), 1);
        tick();
        drive(1'b1, 8'd10, 8'd12, 4'd2);
        #1;
        check("bub_ready2", 32'(bus.in_ready), 1);
        tick();
        drive(1'b0, 8'd0, 8'd0, 4'd0);
        check("bub_ready3", 32'(bus.in_ready), 1);
        tick();
        check("bub_ready4", 32'(bus.in_ready), 1);
        check("bub_head_p", 32'(bus.out_p), 32'd81);
        bus.out_ready = 1'b1;
        tick();
        check("bub_next_valid", 32'(bus.out_valid), 1);
        check("bub_next_p", 32'(bus.out_p), 32'd120);
        tick();
        check("bub_empty", 32'(bus.out_valid), 0);

        // Asynchronous reset with three products in flight
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 8'(c + 50), 8'(c + 60), 4'(c + 4));
            tick();
        end
        drive(1'b0, 8'd0, 8'd0, 4'd0);
        #2;
        rst_n = 1'b0;
        sb.delete();
        exp_cnt = '0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 0);
        check("mid_rst_p", 32'(bus.out_p), 0);
        check("mid_rst_cnt", 32'(prod_cnt), 0);
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("no_stale", 32'(bus.out_valid), 0);
        end
        drive(1'b1, 8'd77, 8'd3, 4'd9);
        tick();
        drive(1'b0, 8'd0, 8'd0, 4'd0);
        tick();
        tick();
        check("fresh_valid", 32'(bus.out_valid), 1);
        check("fresh_p", 32'(bus.out_p), 32'd231);
        check("fresh_tag", 32'(bus.out_tag), 9);
        tick();

        // Counter wrap (4-bit counter, 17 products)
        #2;
        rst_n = 1'b0;
        sb.delete();
        exp_cnt = '0;
        #4;
        rst_n = 1'b1;
        tick();
        for (int c = 0; c < 20; c++) begin
            if (c < 17) drive(1'b1, 8'(c), 8'(c + 3), 4'(c));
            else drive(1'b0, 8'd0, 8'd0, 4'd0);
            tick();
            if (c == 17) check("wrap_15", 32'(prod_cnt), 15);
            if (c == 18) check("wrap_0", 32'(prod_cnt), 0);
            if (c == 19) check("wrap_1", 32'(prod_cnt), 1);
        end

        // Randomised soak
        accepted = 0;
        for (int cyc = 0; cyc < 60000 && accepted < 10000; cyc++) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 4'($urandom));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.in_valid && bus.in_ready) accepted++;
            tick();
        end
        check("soak_accepted", 32'(accepted), 10000);
        drive(1'b0, 8'd0, 8'd0, 4'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        check("soak_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
